cursor_select_ctrl: RTL

- Turns the on-screen cursor position and the USB mouse buttons into chess-square selections, and sequences them as piece pick-up then drop.
- Issues a move to the game logic over a valid/ready handshake.
- Sits between the cursor position block / USB button register and the board-state and move-legality logic. Also drives the square-highlight overlay for the VGA renderer.

---
 rtl/cursor_select_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cursor_select_ctrl.sv
// Cursor/button to chess-move controller: maps the cursor to a board square, debounces the
// mouse buttons and sequences pick-up (source) then drop (destination) into a move request.
module cursor_select_ctrl #(
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter int SQ       = 60,
  parameter int DEBOUNCE = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic [7:0] btn,
  input  logic       own_piece,
  input  logic       move_ready,
  output logic [2:0] hover_col,
  output logic [2:0] hover_row,
  output logic       hover_on,
  output logic [2:0] q_col,
  output logic [2:0] q_row,
  output logic       hl_valid,
  output logic [2:0] hl_col,
  output logic [2:0] hl_row,
  output logic       move_valid,
  output logic [2:0] src_col,
  output logic [2:0] src_row,
  output logic [2:0] dst_col,
  output logic [2:0] dst_row,
  output logic [2:0] state_dbg
);

  typedef enum logic [1:0] {StIdle = 2'd0, StCheck = 2'd1, StHeld = 2'd2, StReq = 2'd3} state_e;

  state_e state_q, state_d;

  int         xi, yi;
  logic       sq_on;
  logic [2:0] sq_col, sq_row;

  // Debounce state, index 0 = left button, 1 = right button
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [1:0]      arm_q, arm_d, click;
  logic            lclick, rclick;

  logic [2:0] hover_col_d, hover_row_d;
  logic [2:0] q_col_d, q_row_d, src_col_d, src_row_d, dst_col_d, dst_row_d;

  // Cursor to square mapping via a compare chain against multiples of SQ
  always_comb begin
    xi     = {22'd0, mouse_x};
    yi     = {22'd0, mouse_y};
    sq_on  = (xi >= BOARD_X0) && (xi < BOARD_X0 + 8 * SQ) &&
             (yi >= BOARD_Y0) && (yi < BOARD_Y0 + 8 * SQ);
    sq_col = 3'd0;
    sq_row = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (xi >= BOARD_X0 + i * SQ) sq_col = 3'(i);
      if (yi >= BOARD_Y0 + i * SQ) sq_row = 3'(i);
    end
  end

  // Saturating press counters; a click fires once on the cycle the count reaches DEBOUNCE
  always_comb begin
    cnt_d = cnt_q;
    arm_d = arm_q;
    click = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (btn[b]) begin
        cnt_d[b] = (cnt_q[b] == 4'd15) ? cnt_q[b] : cnt_q[b] + 4'd1;
        click[b] = arm_q[b] && (({1'b0, cnt_q[b]} + 5'd1) == 5'(DEBOUNCE));
        if (click[b]) arm_d[b] = 1'b0;
      end else begin
        cnt_d[b] = 4'd0;
        arm_d[b] = 1'b1;
      end
    end
    // Right button is cancel and overrides a simultaneous left click
    rclick = click[1];
    lclick = click[0] & ~click[1];
  end

  // Selection FSM next-state and square latches
  always_comb begin
    state_d     = state_q;
    q_col_d     = q_col;
    q_row_d     = q_row;
    src_col_d   = src_col;
    src_row_d   = src_row;
    dst_col_d   = dst_col;
    dst_row_d   = dst_row;
    hover_col_d = sq_on ? sq_col : hover_col;
    hover_row_d = sq_on ? sq_row : hover_row;
    unique case (state_q)
      StIdle: begin
        if (lclick && sq_on) begin
          q_col_d   = sq_col;
          q_row_d   = sq_row;
          src_col_d = sq_col;
          src_row_d = sq_row;
          state_d   = StCheck;
        end
      end
      StCheck: state_d = own_piece ? StHeld : StIdle;
      StHeld: begin
        if (rclick || (lclick && !sq_on)) begin
          state_d = StIdle;
        end else if (lclick) begin
          if (sq_col == src_col && sq_row == src_row) begin
            state_d = StIdle;
          end else begin
            dst_col_d = sq_col;
            dst_row_d = sq_row;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        if (move_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      arm_q     <= 2'b11;
      hover_col <= 3'd0;
      hover_row <= 3'd0;
      hover_on  <= 1'b0;
      q_col     <= 3'd0;
      q_row     <= 3'd0;
      src_col   <= 3'd0;
      src_row   <= 3'd0;
      dst_col   <= 3'd0;
      dst_row   <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      hover_col <= hover_col_d;
      hover_row <= hover_row_d;
      hover_on  <= sq_on;
      q_col     <= q_col_d;
      q_row     <= q_row_d;
      src_col   <= src_col_d;
      src_row   <= src_row_d;
      dst_col   <= dst_col_d;
      dst_row   <= dst_row_d;
    end
  end

  assign move_valid = (state_q == StReq);
  assign hl_valid   = (state_q == StHeld) || (state_q == StReq);
  assign hl_col     = src_col;
  assign hl_row     = src_row;
  assign state_dbg  = {1'b0, state_q};

endmodule
